// File: rtl/keycode_tone_gen.sv
// rtl/keycode_tone_gen.sv - scan-code decoder, phase accumulator and ASR envelope producing PCM samples.
// Optional macro KEYCODE_TONE_TRIANGLE_EN selects a triangle waveform instead of the default square.
module keycode_tone_gen #(
    parameter int SAMPLE_W     = 16,
    parameter int ATTACK_STEP  = 8,
    parameter int RELEASE_STEP = 2
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [7:0]                 key_code,
    input  logic                       sample_tick,
    output logic signed [SAMPLE_W-1:0] sample_out,
    output logic                       sample_valid,
    output logic                       note_active,
    output logic [3:0]                 note_index
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ATTACK,
        S_SUSTAIN,
        S_RELEASE
    } state_t;

    state_t      state, state_n;
    logic [7:0]  key_q;
    logic [23:0] phase, phase_n;
    logic [23:0] inc, inc_n;
    logic [7:0]  env, env_n;
    logic [3:0]  note_n;

    logic [3:0]  dec_idx;
    logic [23:0] dec_inc;
    logic        press, release_ev;
    logic [8:0]  env_up;
    logic [7:0]  env_dn;
    logic [15:0] wave;

    always_comb begin
        dec_idx = 4'd0;
        dec_inc = 24'd0;
        case (key_q)
            8'h2b: begin dec_idx = 4'd1; dec_inc = 24'd91447;  end
            8'h34: begin dec_idx = 4'd2; dec_inc = 24'd102642; end
            8'h33: begin dec_idx = 4'd3; dec_inc = 24'd115214; end
            8'h3b: begin dec_idx = 4'd4; dec_inc = 24'd122065; end
            8'h42: begin dec_idx = 4'd5; dec_inc = 24'd137014; end
            8'h4b: begin dec_idx = 4'd6; dec_inc = 24'd153791; end
            8'h4c: begin dec_idx = 4'd7; dec_inc = 24'd172623; end
            8'h52: begin dec_idx = 4'd8; dec_inc = 24'd182889; end
            default: begin dec_idx = 4'd0; dec_inc = 24'd0; end
        endcase
    end

    assign press      = (dec_idx != 4'd0) &&
                        ((dec_idx != note_index) || (state == S_RELEASE) || (state == S_IDLE));
    assign release_ev = (dec_idx == 4'd0) && ((state == S_ATTACK) || (state == S_SUSTAIN));
    assign env_up     = {1'b0, env} + 9'(ATTACK_STEP);
    assign env_dn     = (env <= 8'(RELEASE_STEP)) ? 8'd0 : env - 8'(RELEASE_STEP);
    assign note_active = (state != S_IDLE);

`ifdef KEYCODE_TONE_TRIANGLE_EN
    logic [7:0]         tri_t;
    logic signed [8:0]  tri_val;
    logic signed [17:0] tri_prod;
    always_comb begin
        tri_t    = phase[23] ? ~phase[22:15] : phase[22:15];
        tri_val  = $signed({1'b0, tri_t}) - 9'sd128;
        tri_prod = 18'(tri_val) * 18'($signed({1'b0, env}));
        wave     = tri_prod[15:0];
    end
`else
    logic [15:0] env_scaled;
    always_comb begin
        env_scaled = {1'b0, env, 7'b0};
        wave       = phase[23] ? (16'd0 - env_scaled) : env_scaled;
    end
`endif

    // Key events take priority over envelope stepping; phase always advances with the current inc.
    always_comb begin
        state_n = state;
        phase_n = sample_tick ? phase + inc : phase;
        inc_n   = inc;
        env_n   = env;
        note_n  = note_index;
        if (press) begin
            state_n = S_ATTACK;
            inc_n   = dec_inc;
            note_n  = dec_idx;
        end else if (release_ev) begin
            state_n = S_RELEASE;
        end else if (sample_tick) begin
            case (state)
                S_ATTACK: begin
                    if (env_up >= 9'd255) begin
                        env_n   = 8'd255;
                        state_n = S_SUSTAIN;
                    end else begin
                        env_n = env_up[7:0];
                    end
                end
                S_RELEASE: begin
                    env_n = env_dn;
                    if (env_dn == 8'd0) begin
                        state_n = S_IDLE;
                        note_n  = 4'd0;
                        inc_n   = 24'd0;
                        phase_n = 24'd0;
                    end
                end
                default: begin
                    env_n = env;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            key_q        <= 8'hf0;
            state        <= S_IDLE;
            phase        <= 24'd0;
            inc          <= 24'd0;
            env          <= 8'd0;
            note_index   <= 4'd0;
            sample_out   <= '0;
            sample_valid <= 1'b0;
        end else begin
            key_q        <= key_code;
            state        <= state_n;
            phase        <= phase_n;
            inc          <= inc_n;
            env          <= env_n;
            note_index   <= note_n;
            sample_valid <= sample_tick;
            if (sample_tick) begin
                sample_out <= wave;
            end
        end
    end

endmodule

// File: doc/keycode_tone_gen.md
Name: keycode_tone_gen

Overview:
- Downstream consumer of the scan-code note sequencer.
- Takes the 8-bit PS/2-style key_code stream (note code held while pressed, 8'hf0 = release/idle) and turns it into a signed PCM audio sample stream.
- Contents: scan-code decoder, 24-bit phase accumulator, and a 4-state attack/sustain/release envelope.
- Feeds the audio codec serializer, one sample per sample_tick.

Parameters:
- SAMPLE_W, 16, output sample width. Only 16 is supported; the amplitude mapping is fixed to it.
- ATTACK_STEP, 8, envelope increment per sample_tick in ATTACK (1..255).
- RELEASE_STEP, 2, envelope decrement per sample_tick in RELEASE (1..255).

Ports:
- clock  input  1  system clock; all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- key_code  input  8  scan code from the note sequencer; 8'hf0 or any unmapped code means no key.
- sample_tick  input  1  one-cycle strobe at 48 kHz audio rate.
- sample_out  output  SAMPLE_W  signed two's-complement sample.
- sample_valid  output  1  one-cycle pulse; sample_out is new this cycle.
- note_active  output  1  high in ATTACK, SUSTAIN and RELEASE.
- note_index  output  4  current note, 1..8; 0 when IDLE.

Behaviour:
- Reset values:
  - sample_out=0, sample_valid=0, note_active=0, note_index=0.
  - State IDLE; phase=0, inc=0, env=0; key register=8'hf0.
- Input stage: key_code is registered every cycle into key_q. Decode operates on key_q.
- Decode table (key_q to index, inc):
  - 2b to 1, 91447
  - 34 to 2, 102642
  - 33 to 3, 115214
  - 3b to 4, 122065
  - 42 to 5, 137014
  - 4b to 6, 153791
  - 4c to 7, 172623
  - 52 to 8, 182889
  - Any other code, including f0, decodes to index 0 (no key).
- Events are evaluated every clock, not only on sample_tick:
  - press: decoded index != 0 and index != note_index, or index != 0 while in RELEASE or IDLE.
  - release: decoded index == 0 while in ATTACK or SUSTAIN.
- FSM transitions:
  - IDLE, on press: go to ATTACK, latch inc and note_index.
  - ATTACK, on tick: env = min(env+ATTACK_STEP, 255). When the result is 255, go to SUSTAIN.
  - SUSTAIN: env held at 255.
  - ATTACK or SUSTAIN, on press of a different note: go to ATTACK with the new inc. env and phase are retained (no click).
  - ATTACK or SUSTAIN, on release: go to RELEASE. note_index is retained.
  - RELEASE, on tick: env = max(env-RELEASE_STEP, 0). When the result is 0, go to IDLE: note_index=0, inc=0, phase=0.
  - RELEASE, on press: go to ATTACK with the new note, from the current env.
- Key-to-state latency: key_code change at edge n leads to key_q at n+1 and state/note_index update at n+2.
- On a sample_tick cycle, at that clock edge:
  - sample_out <= f(phase, env), computed from pre-update values.
  - phase <= phase + inc, mod 2^24 (wraps silently).
  - env steps per current state.
  - sample_valid <= 1, for exactly one cycle.
- Square waveform: f = phase[23] ? -(env<<7) : +(env<<7). Full scale is +/-32640; no overflow.
- Simultaneous event and tick:
  - The state transition wins; env does not step on that tick.
  - phase advances with the old inc; the new inc takes effect from the next tick.
  - sample_valid still pulses.
- Back-to-back ticks (every cycle) must be supported.
- Reset asserted mid-note: all registers return to reset values on the next edge; sample_out is 0 immediately after.

Optional Feature:
- Macro: KEYCODE_TONE_TRIANGLE_EN.
- Defined: triangle waveform.
  - t = phase[23] ? ~phase[22:15] : phase[22:15], giving 8 bits.
  - tri = t - 128, signed 9-bit.
  - f = tri * env, signed 17-bit product, truncated to 16 bits. Range is -32640..32385, so the truncation is lossless.
- Undefined: square waveform as above.
- FSM, timing and ports are identical in both builds.

Test Plan:
- Reset, then key_code=8'hf0 with 100 ticks: sample_out=0, note_active=0, note_index=0, and sample_valid pulses once per tick.
- key_code=8'h2b: note_index=1 two cycles later. After 32 ticks env=255 (8*32 saturates) and state is SUSTAIN. phase increases by 91447 per tick, and the square sample equals +/-32640 with sign given by phase[23].
- While sustaining note 1, switch key_code to 8'h42: note_index=5, inc=137014, and env continues from 255 (no drop to 0). phase is continuous across the switch.
- key_code=8'hf0 from SUSTAIN: RELEASE. After 128 ticks env=0, state IDLE, note_index=0, phase=0, sample_out=0.
- Release, then re-press 8'h2b after 10 ticks: ATTACK resumes from env=235; SUSTAIN after 3 more ticks.
- Event and tick in the same cycle, plus reset asserted during ATTACK: env is unchanged on that tick; reset returns all outputs to 0 on the next edge. With KEYCODE_TONE_TRIANGLE_EN, phase=0 and env=255 give sample_out=-32640.
